spu_mem_stage: RTL and testbench

SPU memory stage. Sits between the EX/MEM pipeline register and the MEM/WB register, and feeds readData, ALUResult, RegisterRT and reg_write to MEM/WB. Quadword loads and stores go to the local store (LS) through a req/ack handshake. The stage stalls upstream while an access is outstanding. Non-memory instructions pass through with one cycle of latency.

---
 rtl/spu_mem_stage.sv | 174 +++++++++++++++++
 tb/tb_spu_mem_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/spu_mem_stage.sv
// spu_mem_stage: SPU memory stage between EX/MEM and MEM/WB.
// Quadword loads/stores go to the local store over a req/ack handshake.
// Upstream is stalled while an access is outstanding. Non-memory
// instructions pass through with one cycle of latency.
//
// Ports:
//   clk, reset (async, active-low)
//   valid_in, is_load_in, is_store_in, addr_in, store_data_in,
//   ALUResult_in, RegisterRT_in, reg_write_in  : from EX/MEM
//   stall                                      : hold upstream
//   ls_req, ls_we, ls_addr, ls_wdata           : to local store
//   ls_ack, ls_rdata                           : from local store
//   valid_out, readData_out, ALUResult_out,
//   RegisterRT_out, reg_write_out, mem_err     : to MEM/WB
module spu_mem_stage #(
    parameter int unsigned DATA_W         = 128,
    parameter int unsigned REG_W          = 7,
    parameter int unsigned LS_ADDR_W      = 18,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid_in,
    input  logic                   is_load_in,
    input  logic                   is_store_in,
    input  logic [LS_ADDR_W-1:0]   addr_in,
    input  logic [DATA_W-1:0]      store_data_in,
    input  logic [DATA_W-1:0]      ALUResult_in,
    input  logic [REG_W-1:0]       RegisterRT_in,
    input  logic                   reg_write_in,
    output logic                   stall,
    output logic                   ls_req,
    output logic                   ls_we,
    output logic [LS_ADDR_W-5:0]   ls_addr,
    output logic [DATA_W-1:0]      ls_wdata,
    input  logic                   ls_ack,
    input  logic [DATA_W-1:0]      ls_rdata,
    output logic                   valid_out,
    output logic [DATA_W-1:0]      readData_out,
    output logic [DATA_W-1:0]      ALUResult_out,
    output logic [REG_W-1:0]       RegisterRT_out,
    output logic                   reg_write_out,
    output logic                   mem_err
);

    localparam int unsigned CNT_W =
        (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               timeout_hit;
    logic               accept, pass, finish_ack, finish_to;

    logic [DATA_W-1:0]  lat_alu;
    logic [REG_W-1:0]   lat_rt;
    logic               lat_rw;

    // Quadword addressing: the low nibble is intentionally dropped.
    logic               unused_addr_lo;
    assign unused_addr_lo = ^addr_in[3:0];

    assign stall       = (state == ACCESS);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == TO_VAL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        pass       = 1'b0;
        finish_ack = 1'b0;
        finish_to  = 1'b0;
        case (state)
            IDLE: begin
                if (valid_in) begin
                    if (is_load_in || is_store_in) begin
                        accept    = 1'b1;
                        state_nxt = ACCESS;
                    end else begin
                        pass = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // ack takes priority over a coincident timeout
                if (ls_ack) begin
                    finish_ack = 1'b1;
                    state_nxt  = IDLE;
                end else if (timeout_hit) begin
                    finish_to = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt            <= '0;
            lat_alu        <= '0;
            lat_rt         <= '0;
            lat_rw         <= 1'b0;
            ls_req         <= 1'b0;
            ls_we          <= 1'b0;
            ls_addr        <= '0;
            ls_wdata       <= '0;
            valid_out      <= 1'b0;
            readData_out   <= '0;
            ALUResult_out  <= '0;
            RegisterRT_out <= '0;
            reg_write_out  <= 1'b0;
            mem_err        <= 1'b0;
        end else begin
            valid_out     <= 1'b0;
            reg_write_out <= 1'b0;
            mem_err       <= 1'b0;

            if (pass) begin
                valid_out      <= 1'b1;
                ALUResult_out  <= ALUResult_in;
                RegisterRT_out <= RegisterRT_in;
                reg_write_out  <= reg_write_in;
                readData_out   <= '0;
            end

            if (accept) begin
                lat_alu  <= ALUResult_in;
                lat_rt   <= RegisterRT_in;
                lat_rw   <= reg_write_in;
                ls_addr  <= addr_in[LS_ADDR_W-1:4];
                ls_we    <= is_store_in;
                ls_wdata <= store_data_in;
                ls_req   <= 1'b1;
                cnt      <= '0;
            end

            // Saturating counter: stops at the timeout value (or all-ones
            // when the timeout is disabled).
            if (state == ACCESS && !ls_ack && !timeout_hit && cnt != '1)
                cnt <= cnt + 1'b1;

            if (finish_ack) begin
                ls_req         <= 1'b0;
                valid_out      <= 1'b1;
                ALUResult_out  <= lat_alu;
                RegisterRT_out <= lat_rt;
                if (ls_we) begin
                    readData_out  <= '0;
                    reg_write_out <= 1'b0;
                end else begin
                    readData_out  <= ls_rdata;
                    reg_write_out <= lat_rw;
                end
            end

            if (finish_to) begin
                ls_req         <= 1'b0;
                valid_out      <= 1'b1;
                mem_err        <= 1'b1;
                readData_out   <= '0;
                ALUResult_out  <= lat_alu;
                RegisterRT_out <= lat_rt;
            end
        end
    end

endmodule

// File: tb/tb_spu_mem_stage.sv
// tb_spu_mem_stage: randomized self-checking bench for spu_mem_stage with
// a transaction-level reference model (timeout set to 4 cycles).
module tb_spu_mem_stage;

    localparam int unsigned DW = 128;
    localparam int unsigned RW = 7;
    localparam int unsigned AW = 18;
    localparam int unsigned TO = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           valid_in, is_load_in, is_store_in, reg_write_in;
    logic [AW-1:0]  addr_in;
    logic [DW-1:0]  store_data_in, ALUResult_in;
    logic [RW-1:0]  RegisterRT_in;
    logic           stall, ls_req, ls_we, ls_ack;
    logic [AW-5:0]  ls_addr;
    logic [DW-1:0]  ls_wdata, ls_rdata;
    logic           valid_out, reg_write_out, mem_err;
    logic [DW-1:0]  readData_out, ALUResult_out;
    logic [RW-1:0]  RegisterRT_out;

    int n_tests = 0;
    int n_fail  = 0;

    // model of the held output registers
    logic [DW-1:0]  m_rd, m_alu;
    logic [RW-1:0]  m_rt;

    spu_mem_stage #(
        .DATA_W(DW), .REG_W(RW), .LS_ADDR_W(AW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .valid_in(valid_in), .is_load_in(is_load_in), .is_store_in(is_store_in),
        .addr_in(addr_in), .store_data_in(store_data_in),
        .ALUResult_in(ALUResult_in), .RegisterRT_in(RegisterRT_in),
        .reg_write_in(reg_write_in), .stall(stall),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ack(ls_ack), .ls_rdata(ls_rdata),
        .valid_out(valid_out), .readData_out(readData_out),
        .ALUResult_out(ALUResult_out), .RegisterRT_out(RegisterRT_out),
        .reg_write_out(reg_write_out), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at a negedge; returns at a negedge with valid_in dropped.
    // kind: 0 ALU, 1 load, 2 store, 3 load+store. delay: ACCESS cycles
    // before ls_ack rises; beyond TO the access must time out.
    task automatic run_op(input int kind, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [DW-1:0] alu,
                          input logic [RW-1:0] rt, input logic rw,
                          input int delay, input logic [DW-1:0] rdata);
        int  k;
        bit  seen;
        bit  is_ld, is_st, timed_out;
        is_ld = (kind == 1) || (kind == 3);
        is_st = (kind == 2) || (kind == 3);
        valid_in      = 1'b1;
        is_load_in    = is_ld;
        is_store_in   = is_st;
        addr_in       = addr;
        store_data_in = wdata;
        ALUResult_in  = alu;
        RegisterRT_in = rt;
        reg_write_in  = rw;
        ls_ack        = 1'b0;
        @(posedge clk); @(negedge clk);
        if (kind == 0) begin
            check("alu_valid", valid_out, 1);
            check("alu_stall", stall, 0);
            check("alu_result", ALUResult_out, alu);
            check("alu_rt", RegisterRT_out, rt);
            check("alu_rw", reg_write_out, rw);
            check("alu_rdata", readData_out, 0);
            check("alu_err", mem_err, 0);
            m_alu = alu; m_rt = rt; m_rd = '0;
        end else begin
            check("req_addr", ls_addr, addr >> 4);
            check("req_we", ls_we, is_st);
            if (is_st) check("req_wdata", ls_wdata, wdata);
            k = 0;
            seen = 0;
            while (k < 20) begin
                check("acc_stall", stall, 1);
                check("acc_req", ls_req, 1);
                check("acc_valid", valid_out, 0);
                ls_ack   = (k == delay);
                ls_rdata = (k == delay) ? rdata : rand128();
                @(posedge clk); @(negedge clk);
                if (valid_out) begin
                    seen = 1;
                    break;
                end
                k++;
            end
            ls_ack = 1'b0;
            if (!seen) begin
                check("wait_valid", 0, 1);
            end else begin
                timed_out = (delay > TO);
                check("stall_cycles", k + 1, (timed_out ? TO : delay) + 1);
                check("done_stall", stall, 0);
                check("done_req", ls_req, 0);
                check("done_err", mem_err, timed_out);
                check("done_alu", ALUResult_out, alu);
                check("done_rt", RegisterRT_out, rt);
                if (timed_out || is_st) begin
                    check("done_rdata", readData_out, 0);
                    check("done_rw", reg_write_out, 0);
                    m_rd = '0;
                end else begin
                    check("done_rdata", readData_out, rdata);
                    check("done_rw", reg_write_out, rw);
                    m_rd = rdata;
                end
                m_alu = alu; m_rt = rt;
            end
        end
        valid_in = 1'b0;
    endtask

    // One idle cycle, optionally with a stray ack.
    task automatic idle_cycle(input logic stray);
        valid_in = 1'b0;
        ls_ack   = stray;
        ls_rdata = rand128();
        @(posedge clk); @(negedge clk);
        ls_ack = 1'b0;
        check("idle_valid", valid_out, 0);
        check("idle_req", ls_req, 0);
        check("idle_stall", stall, 0);
        check("idle_rw", reg_write_out, 0);
        check("idle_err", mem_err, 0);
        check("idle_hold_rd", readData_out, m_rd);
        check("idle_hold_alu", ALUResult_out, m_alu);
        check("idle_hold_rt", RegisterRT_out, m_rt);
    endtask

    initial begin
        reset = 1'b0;
        valid_in = 0; is_load_in = 0; is_store_in = 0; reg_write_in = 0;
        addr_in = '0; store_data_in = '0; ALUResult_in = '0; RegisterRT_in = '0;
        ls_ack = 0; ls_rdata = '0;
        m_rd = '0; m_alu = '0; m_rt = '0;
        #1;
        check("rst_valid", valid_out, 0);
        check("rst_req", ls_req, 0);
        check("rst_stall", stall, 0);
        check("rst_alu", ALUResult_out, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;

        // directed: ALU pass, load (3-cycle ack), store same-cycle ack
        // followed back to back by an ALU op, timeout, stray ack, dual flags
        run_op(0, '0, '0, 128'hDEAD, 7'd5, 1'b1, 0, '0);
        idle_cycle(1'b0);
        run_op(1, 18'h00123, '0, 128'h11, 7'd9, 1'b1, 2, 128'hA5A5);
        run_op(2, 18'h00040, 128'h55, 128'h22, 7'd3, 1'b1, 0, '0);
        run_op(0, '0, '0, 128'h77, 7'd4, 1'b1, 0, '0);
        run_op(1, 18'h3FFF0, '0, 128'h33, 7'd8, 1'b1, 100, '0);
        idle_cycle(1'b1);
        run_op(3, 18'h00010, 128'h99, 128'h44, 7'd10, 1'b1, 1, 128'hBEEF);
        run_op(1, 18'h00200, '0, 128'h66, 7'd12, 1'b1, TO, 128'hCAFE);

        // reset during an outstanding access
        valid_in = 1; is_load_in = 1; is_store_in = 0; addr_in = 18'h100;
        ALUResult_in = 128'h5; RegisterRT_in = 7'd1; reg_write_in = 1;
        @(posedge clk); @(negedge clk);
        valid_in = 0;
        check("mid_req", ls_req, 1);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check("mid_rst_req", ls_req, 0);
        check("mid_rst_stall", stall, 0);
        check("mid_rst_valid", valid_out, 0);
        check("mid_rst_alu", ALUResult_out, 0);
        @(negedge clk);
        reset = 1'b1;
        m_rd = '0; m_alu = '0; m_rt = '0;
        idle_cycle(1'b0);
        run_op(0, '0, '0, 128'hF00D, 7'd2, 1'b1, 0, '0);

        // randomized mix
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom_range(0, 1)));
            run_op(int'($urandom_range(0, 3)), AW'($urandom), rand128(), rand128(),
                   RW'($urandom), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 6)), rand128());
        end
        idle_cycle(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
